// File: rtl/ysyx_24110006_mdu_pkg.sv
// ysyx_24110006_mdu_pkg: shared RV32M funct3 encodings, FSM states and operand-signedness helpers
package ysyx_24110006_mdu_pkg;
  typedef enum logic [2:0] {
    F_MUL    = 3'b000,
    F_MULH   = 3'b001,
    F_MULHSU = 3'b010,
    F_MULHU  = 3'b011,
    F_DIV    = 3'b100,
    F_DIVU   = 3'b101,
    F_REM    = 3'b110,
    F_REMU   = 3'b111
  } func_e;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;
  function automatic logic sgn_a(func_e f);
    return f inside {F_MULH, F_MULHSU, F_DIV, F_REM};
  endfunction
  function automatic logic sgn_b(func_e f);
    return f inside {F_MULH, F_DIV, F_REM};
  endfunction
endpackage

// File: rtl/ysyx_24110006_mdu_if.sv
// ysyx_24110006_mdu_if: request/result handshake bundle of the MDU
// slave = MDU side; master = pipeline side (issues i_*, receives o_*)
interface ysyx_24110006_mdu_if #(
  parameter int XLEN = 32,
  parameter int TAG_W = 5
);
  logic i_valid, o_ready, i_flush, o_valid, i_ready, o_busy;
  logic [2:0] i_func;
  logic [XLEN-1:0] i_src1, i_src2, o_result;
  logic [TAG_W-1:0] i_rd, o_rd;
  modport slave (
    input i_valid, i_func, i_src1, i_src2, i_rd, i_flush, i_ready,
    output o_ready, o_valid, o_result, o_rd, o_busy
  );
  modport master (
    output i_valid, i_func, i_src1, i_src2, i_rd, i_flush, i_ready,
    input o_ready, o_valid, o_result, o_rd, o_busy
  );
endinterface

// File: rtl/ysyx_24110006_mdu_div_iter.sv
// ysyx_24110006_DIV_ITER: magnitude restoring divider step plus iteration counter
// i_start loads operands and clears the counter; i_step advances one bit; o_quot/o_rem are the post-step values
module ysyx_24110006_DIV_ITER #(
  parameter int XLEN = 32,
  parameter int CW = 6
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic            i_step,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_quot,
  output logic [XLEN-1:0] o_rem,
  output logic [CW-1:0]   o_cnt
);
  logic [XLEN-1:0] q_q, q_d, r_q, r_d, d_q, d_d, diff;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [XLEN:0] shifted;
  logic ge;
  always_comb begin
    shifted = {r_q, q_q[XLEN-1]};
    ge = shifted >= {1'b0, d_q};
    diff = shifted[XLEN-1:0] - d_q;
    o_rem = ge ? diff : shifted[XLEN-1:0];
    o_quot = {q_q[XLEN-2:0], ge};
    q_d = i_start ? i_dividend : i_step ? o_quot : q_q;
    r_d = i_start ? '0 : i_step ? o_rem : r_q;
    d_d = i_start ? i_divisor : d_q;
    cnt_d = i_start ? '0 : (i_step && cnt_q != CW'(XLEN)) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) begin
      q_q <= '0;
      r_q <= '0;
      d_q <= '0;
      cnt_q <= '0;
    end else begin
      q_q <= q_d;
      r_q <= r_d;
      d_q <= d_d;
      cnt_q <= cnt_d;
    end
  assign o_cnt = cnt_q;
endmodule

// File: rtl/ysyx_24110006_mdu.sv
// ysyx_24110006_mdu: RV32M multiply/divide unit, iterative (or single-cycle multiply) with valid/ready handshake
// ports: i_clock, i_reset (async active high), bus (slave: request, flush, result handshake, busy)
module ysyx_24110006_mdu
  import ysyx_24110006_mdu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int TAG_W = 5,
  parameter int FAST_MUL = 0
) (
  input logic i_clock,
  input logic i_reset,
  ysyx_24110006_mdu_if.slave bus
);
  localparam int CW = $clog2(XLEN) + 1;
  function automatic logic [XLEN-1:0] mag(logic [XLEN-1:0] x, logic s);
    return (s && x[XLEN-1]) ? -x : x;
  endfunction
  function automatic logic [XLEN-1:0] mul_res(func_e f, logic [2*XLEN-1:0] p, logic n);
    logic [2*XLEN-1:0] s;
    s = n ? -p : p;
    return f == F_MUL ? s[XLEN-1:0] : s[2*XLEN-1:XLEN];
  endfunction
  state_e state_q, state_d;
  func_e func_q, func_d, f_in;
  logic [XLEN-1:0] src1_q, src1_d, src2_q, src2_d, res_q, res_d;
  logic [TAG_W-1:0] rd_q, rd_d;
  logic [2*XLEN-1:0] prod_q, prod_d, fast_prod, step_prod;
  logic [XLEN:0] mul_sum;
  logic [XLEN-1:0] ma_in, mb_in, ma, q_nxt, r_nxt, quot, rem, div_res, spec_res;
  logic [CW-1:0] cnt;
  logic accept, neg_in, neg, last, div_zero, div_ovf;
  assign f_in = func_e'(bus.i_func);
  assign accept = bus.i_valid && state_q == S_IDLE && !bus.i_flush;
  // both datapaths work on magnitudes; the sign is reapplied when the result is captured
  assign ma_in = mag(bus.i_src1, sgn_a(f_in));
  assign mb_in = mag(bus.i_src2, sgn_b(f_in));
  assign neg_in = (sgn_a(f_in) && bus.i_src1[XLEN-1]) ^ (sgn_b(f_in) && bus.i_src2[XLEN-1]);
  assign fast_prod = {{XLEN{1'b0}}, ma_in} * {{XLEN{1'b0}}, mb_in};
  assign ma = mag(src1_q, sgn_a(func_q));
  assign neg = (sgn_a(func_q) && src1_q[XLEN-1]) ^ (sgn_b(func_q) && src2_q[XLEN-1]);
  // prod_q = {partial sum, remaining multiplier bits}; add multiplicand on LSB, then shift right
  assign mul_sum = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, ma} : '0);
  assign step_prod = {mul_sum, prod_q[XLEN-1:1]};
  assign last = cnt == CW'(XLEN - 1);
  assign div_zero = src2_q == '0;
  assign div_ovf = sgn_b(func_q) && src1_q == {1'b1, {(XLEN-1){1'b0}}} && &src2_q;
  assign quot = neg ? -q_nxt : q_nxt;
  assign rem = (sgn_a(func_q) && src1_q[XLEN-1]) ? -r_nxt : r_nxt;
  assign div_res = func_q[1] ? rem : quot;
  assign spec_res = div_zero ? (func_q[1] ? src1_q : '1) : (func_q[1] ? '0 : src1_q);
  ysyx_24110006_DIV_ITER #(.XLEN(XLEN), .CW(CW)) u_div (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_start    (accept),
    .i_step     (state_q == S_MUL || state_q == S_DIV),
    .i_dividend (ma_in),
    .i_divisor  (mb_in),
    .o_quot     (q_nxt),
    .o_rem      (r_nxt),
    .o_cnt      (cnt)
  );
  always_comb begin
    state_d = state_q;
    func_d = func_q;
    src1_d = src1_q;
    src2_d = src2_q;
    rd_d = rd_q;
    res_d = res_q;
    prod_d = prod_q;
    case (state_q)
      S_IDLE:
        if (accept) begin
          func_d = f_in;
          src1_d = bus.i_src1;
          src2_d = bus.i_src2;
          rd_d = bus.i_rd;
          prod_d = {{XLEN{1'b0}}, mb_in};
          if (!f_in[2] && FAST_MUL != 0) begin
            state_d = S_DONE;
            res_d = mul_res(f_in, fast_prod, neg_in);
          end else state_d = f_in[2] ? S_DIV : S_MUL;
        end
      S_MUL: begin
        prod_d = step_prod;
        if (last) begin
          state_d = S_DONE;
          res_d = mul_res(func_q, step_prod, neg);
        end
      end
      S_DIV:
        if (div_zero || div_ovf) begin
          state_d = S_DONE;
          res_d = spec_res;
        end else if (last) begin
          state_d = S_DONE;
          res_d = div_res;
        end
      S_DONE: state_d = bus.i_ready ? S_IDLE : S_DONE;
    endcase
    if (bus.i_flush) state_d = S_IDLE;
  end
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) begin
      state_q <= S_IDLE;
      func_q <= F_MUL;
      src1_q <= '0;
      src2_q <= '0;
      rd_q <= '0;
      res_q <= '0;
      prod_q <= '0;
    end else begin
      state_q <= state_d;
      func_q <= func_d;
      src1_q <= src1_d;
      src2_q <= src2_d;
      rd_q <= rd_d;
      res_q <= res_d;
      prod_q <= prod_d;
    end
  assign bus.o_ready = state_q == S_IDLE;
  assign bus.o_valid = state_q == S_DONE;
  assign bus.o_busy = state_q != S_IDLE;
  assign bus.o_result = res_q;
  assign bus.o_rd = rd_q;
endmodule

// File: doc/ysyx_24110006_mdu.md
YSYX_24110006_MDU -- requirements
Module: ysyx_24110006_MDU

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand and result width.
REQ-002 SHALL have parameter TAG_W, default 5, destination-register tag width.
REQ-003 SHALL have parameter FAST_MUL, default 0; 1 selects single-cycle multiply, 0 selects iterative shift-add multiply.
REQ-004 SHALL have port i_clock, in, 1, sole clock; all state changes on rising edge.
REQ-005 SHALL have port i_reset, in, 1, asynchronous active-high reset.
REQ-006 SHALL have port i_valid, in, 1, upstream operation valid.
REQ-007 SHALL have port o_ready, out, 1, unit can accept an operation.
REQ-008 SHALL have port i_func, in, 3, RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-009 SHALL have ports i_src1 and i_src2, in, XLEN each, operands rs1 and rs2.
REQ-010 SHALL have port i_rd, in, TAG_W, destination tag carried with the operation.
REQ-011 SHALL have port i_flush, in, 1, kill the operation in flight or pending.
REQ-012 SHALL have port o_valid, out, 1, result valid.
REQ-013 SHALL have port i_ready, in, 1, downstream accepts result.
REQ-014 SHALL have ports o_result, out, XLEN, and o_rd, out, TAG_W, result and its tag.
REQ-015 SHALL have port o_busy, out, 1, high in any state other than IDLE.

Function
REQ-016 SHALL implement the FSM IDLE -> MUL or DIV -> DONE -> IDLE.
REQ-017 SHALL assert o_ready only in IDLE; an operation is accepted on a cycle with i_valid & o_ready & !i_flush.
REQ-018 SHALL register i_func, i_src1, i_src2 and i_rd on acceptance; inputs are ignored after acceptance.
REQ-019 SHALL, with FAST_MUL=0, iterate the multiply for exactly XLEN cycles in MUL, giving result valid XLEN+1 cycles after acceptance.
REQ-020 SHALL, with FAST_MUL=1, go IDLE -> DONE directly on a multiply, giving result valid 1 cycle after acceptance.
REQ-021 SHALL form a 2*XLEN product; MUL returns the low XLEN bits; MULH signed x signed, MULHSU signed x unsigned and MULHU unsigned x unsigned return the high XLEN bits.
REQ-022 SHALL perform a restoring divide on operand magnitudes for XLEN cycles in DIV, then fix the signs: quotient negative iff operand signs differ; remainder takes the dividend sign.
REQ-023 SHALL, on divisor zero, skip DIV and enter DONE next cycle: DIV/DIVU give all ones, REM/REMU give the dividend.
REQ-024 SHALL, on signed overflow (dividend = -2^(XLEN-1), divisor = -1, DIV/REM), skip DIV: DIV gives the dividend, REM gives 0.
REQ-025 SHALL hold o_valid high in DONE with o_result and o_rd stable until i_ready; DONE & i_ready -> IDLE.
REQ-026 SHALL not accept a new operation in the cycle DONE exits (no bypass); o_ready rises the following cycle.
REQ-027 SHALL, when i_flush is high, force the FSM to IDLE next cycle from any state and discard the result; o_valid is low the cycle after the flush.
REQ-028 SHALL let i_flush win over simultaneous i_valid; nothing is accepted that cycle.
REQ-029 SHALL use an iteration counter of width clog2(XLEN)+1 that clears on acceptance and never wraps within an operation.

Reset
REQ-030 SHALL, on i_reset, immediately and asynchronously give state IDLE, o_valid 0, o_ready 1, o_busy 0, o_result 0, o_rd 0 and counter 0.
REQ-031 SHALL abandon an operation in progress when reset is asserted, with no result emitted after release.

Structure
REQ-032 SHALL put the funct3 encodings and the state encoding in the shared common_config include.
REQ-033 SHALL implement the divider datapath as sub-module ysyx_24110006_DIV_ITER (magnitude restoring step plus counter); the multiplier stays inline.

Verification
REQ-034 SHALL cover MULHU with 0xFFFFFFFF x 0xFFFFFFFF, FAST_MUL=0 -> o_result 0xFFFFFFFE, o_valid exactly 33 cycles after acceptance.
REQ-035 SHALL cover DIV with -7 / 2 -> 0xFFFFFFFD (-3), and REM with -7 % 2 -> 0xFFFFFFFF (-1).
REQ-036 SHALL cover DIVU with 5 / 0 -> 0xFFFFFFFF, and REMU with 5 % 0 -> 5, each valid 2 cycles after acceptance.
REQ-037 SHALL cover DIV with 0x80000000 / 0xFFFFFFFF -> 0x80000000, and REM with the same operands -> 0.
REQ-038 SHALL cover i_flush asserted 10 cycles into a DIV -> o_valid never rises, o_ready 1 next cycle, and a following MUL 3 x 4 -> 12.
REQ-039 SHALL cover i_ready held low 5 cycles in DONE -> o_result and o_rd stable and o_ready low throughout.
